muldiv_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 32/64-bit multiply/divide unit. Accepts operations from two requesters over a 4-phase req/done handshake, grants the unit round-robin, drives its operand/start/mode inputs, waits for its `valid`, and returns the 64-bit result. A watchdog recovers the unit if it never completes.

---
 rtl/muldiv_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: two-port round-robin front end for the shared multiply/divide
// unit. It grants one requester, launches the unit, waits for a qualified valid
// (or the watchdog), and returns the result over a 4-phase req/done handshake.
module muldiv_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        op0,
    input  logic        op1,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [63:0] b0,
    input  logic [63:0] b1,
    output logic        done0,
    output logic        done1,
    output logic [63:0] res0,
    output logic [63:0] res1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] u_opera1,
    output logic [63:0] u_opera2,
    output logic        u_muordi,
    output logic        u_start,
    output logic        u_reset,
    input  logic [63:0] u_result,
    input  logic        u_valid,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE, S_FLUSH} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t      state, state_n;
    logic [7:0]  timer, timer_n;
    logic        last, last_n;
    logic        fcnt, fcnt_n;   // set after the first FLUSH cycle
    logic        drop, drop_n;   // owner released req before completion
    logic        grant_n, busy_n, done0_n, done1_n, err0_n, err1_n;
    logic [63:0] res0_n, res1_n, opera2_n;
    logic [31:0] opera1_n;
    logic        muordi_n, start_n, ureset_n;
    logic        pick, req_g, drop_hit;

    // tie goes to the requester that was not served last
    assign pick  = (req0 & req1) ? ~last : req1;
    assign req_g = grant ? req1 : req0;

    // next-state and next-output computation
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        last_n   = last;
        fcnt_n   = fcnt;
        drop_n   = drop;
        grant_n  = grant;
        done0_n  = done0;
        done1_n  = done1;
        err0_n   = err0;
        err1_n   = err1;
        res0_n   = res0;
        res1_n   = res1;
        opera1_n = u_opera1;
        opera2_n = u_opera2;
        muordi_n = u_muordi;
        start_n  = 1'b0;
        ureset_n = u_reset;
        drop_hit = drop | ~req_g;
        case (state)
            S_IDLE: begin
                ureset_n = 1'b0;
                if (req0 | req1) begin
                    grant_n  = pick;
                    opera1_n = pick ? a1 : a0;
                    opera2_n = pick ? b1 : b0;
                    muordi_n = pick ? op1 : op0;
                    start_n  = 1'b1;
                    state_n  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_n = 8'd0;
                drop_n  = 1'b0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                drop_n = drop_hit;
                // the unit's valid from the previous op lingers for two edges
                if (timer >= 8'd2 && u_valid) begin
                    last_n  = grant;
                    state_n = S_IDLE;
                    if (!drop_hit) begin
                        state_n = S_DONE;
                        if (grant) begin
                            res1_n = u_result; done1_n = 1'b1; err1_n = 1'b0;
                        end else begin
                            res0_n = u_result; done0_n = 1'b1; err0_n = 1'b0;
                        end
                    end
                end else if (timer == TO) begin
                    last_n   = grant;
                    ureset_n = 1'b1;
                    fcnt_n   = 1'b0;
                    state_n  = S_FLUSH;
                    if (!drop_hit) begin
                        if (grant) begin
                            res1_n = '0; done1_n = 1'b1; err1_n = 1'b1;
                        end else begin
                            res0_n = '0; done0_n = 1'b1; err0_n = 1'b1;
                        end
                    end
                end else begin
                    timer_n = timer + 8'd1;
                end
            end
            S_DONE: begin
                if (!req_g) begin
                    done0_n = 1'b0; done1_n = 1'b0;
                    err0_n  = 1'b0; err1_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (!fcnt) begin
                    fcnt_n = 1'b1;
                end else begin
                    ureset_n = 1'b0;
                    if (!req_g) begin
                        done0_n = 1'b0; done1_n = 1'b0;
                        err0_n  = 1'b0; err1_n  = 1'b0;
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // state and registered outputs, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_IDLE;
            timer    <= 8'd0;
            last     <= 1'b1;
            fcnt     <= 1'b0;
            drop     <= 1'b0;
            grant    <= 1'b0;
            busy     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            res0     <= '0;
            res1     <= '0;
            u_opera1 <= '0;
            u_opera2 <= '0;
            u_muordi <= 1'b0;
            u_start  <= 1'b0;
            u_reset  <= 1'b1;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            last     <= last_n;
            fcnt     <= fcnt_n;
            drop     <= drop_n;
            grant    <= grant_n;
            busy     <= busy_n;
            done0    <= done0_n;
            done1    <= done1_n;
            err0     <= err0_n;
            err1     <= err1_n;
            res0     <= res0_n;
            res1     <= res1_n;
            u_opera1 <= opera1_n;
            u_opera2 <= opera2_n;
            u_muordi <= muordi_n;
            u_start  <= start_n;
            u_reset  <= ureset_n;
        end
    end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter with a small behavioural mul/div unit model.
module tb_muldiv_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1, op0, op1;
    logic [31:0] a0, a1;
    logic [63:0] b0, b1;
    logic        done0, done1, err0, err1;
    logic [63:0] res0, res1;
    logic [31:0] u_opera1;
    logic [63:0] u_opera2;
    logic        u_muordi, u_start, u_reset;
    logic [63:0] u_result;
    logic        u_valid;
    logic        busy, grant;

    int n_assert = 0;
    int n_fail   = 0;

    // unit model controls
    int          lat   = 5;
    bit          never = 1'b0;
    int          kill  = 0;
    int          cnt   = 0;
    logic [63:0] mres  = '0;

    // monitor state
    int nstart     = 0;
    bit prev_start = 1'b0;
    bit dbl        = 1'b0;
    bit bad0       = 1'b0;
    bit bad1       = 1'b0;

    muldiv_arbiter #(.TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .done0(done0), .done1(done1), .res0(res0), .res1(res1),
        .err0(err0), .err1(err1),
        .u_opera1(u_opera1), .u_opera2(u_opera2), .u_muordi(u_muordi),
        .u_start(u_start), .u_reset(u_reset),
        .u_result(u_result), .u_valid(u_valid),
        .busy(busy), .grant(grant)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // wait (bounded) for done of port idx, then check latency and payload
    task automatic serve(input bit idx, input logic [63:0] exp, input int exp_cyc, input string tag);
        int cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!(idx ? done1 : done0) && cyc < 100);
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_done"}, 64'(idx ? done1 : done0), 64'd1);
        chk({tag, "_res"}, idx ? res1 : res0, exp);
        chk({tag, "_err"}, 64'(idx ? err1 : err0), 64'd0);
    endtask

    // unit model: result after lat cycles; previous valid lingers 3 cycles past start
    initial begin
        u_valid  = 1'b0;
        u_result = '0;
        forever begin
            @(negedge clock);
            if (u_reset) begin
                u_valid = 1'b0;
                cnt     = 0;
                kill    = 0;
            end else if (u_start) begin
                mres = u_muordi ? {32'(u_opera2 % {32'b0, u_opera1}), 32'(u_opera2 / {32'b0, u_opera1})}
                                : u_opera2 * {32'b0, u_opera1};
                cnt  = lat;
                kill = 3;
            end else begin
                if (kill > 0) begin
                    kill--;
                    if (kill == 0) u_valid = 1'b0;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0 && !never) begin
                        u_valid  = 1'b1;
                        u_result = mres;
                    end
                end
            end
        end
    end

    // start-pulse and done/grant monitor
    initial begin
        forever begin
            @(negedge clock);
            if (u_start) begin
                nstart++;
                if (prev_start) dbl = 1'b1;
            end
            prev_start = u_start;
            if (done1 && !grant) bad1 = 1'b1;
            if (done0 && grant)  bad0 = 1'b1;
        end
    end

    initial begin
        int cyc;
        reset = 1'b0; req0 = 1'b1; req1 = 1'b0;
        op0 = 1'b1; a0 = 32'd7; b0 = 64'd100;
        op1 = 1'b0; a1 = '0; b1 = '0;
        lat = 5; never = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_done0", 64'(done0), 64'd0);
        chk("rst_done1", 64'(done1), 64'd0);
        chk("rst_err0", 64'(err0), 64'd0);
        chk("rst_res0", res0, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start", 64'(u_start), 64'd0);
        chk("rst_ureset", 64'(u_reset), 64'd1);
        chk("rst_opera2", u_opera2, 64'd0);
        chk("rst_nstart", 64'(nstart), 64'd0);

        // divide on port 0: 100 / 7 = 14 rem 2
        reset = 1'b1;
        @(negedge clock);
        chk("g0_start", 64'(u_start), 64'd1);
        chk("g0_grant", 64'(grant), 64'd0);
        chk("g0_busy", 64'(busy), 64'd1);
        chk("g0_opera1", 64'(u_opera1), 64'd7);
        chk("g0_opera2", u_opera2, 64'd100);
        chk("g0_muordi", 64'(u_muordi), 64'd1);
        chk("g0_ureset", 64'(u_reset), 64'd0);
        serve(1'b0, 64'h00000002_0000000E, 6, "div");
        repeat (2) @(negedge clock);
        chk("div_hold", 64'(done0), 64'd1);
        chk("div_hold_res", res0, 64'h00000002_0000000E);
        chk("div_nstart", 64'(nstart), 64'd1);
        req0 = 1'b0;
        @(negedge clock);
        chk("div_drop", 64'(done0), 64'd0);
        chk("div_idle", 64'(busy), 64'd0);

        // simultaneous requests right after a reset: port 0 first
        reset = 1'b0;
        @(negedge clock);
        chk("rst2_ureset", 64'(u_reset), 64'd1);
        reset = 1'b1; lat = 4;
        req0 = 1'b1; op0 = 1'b0; a0 = 32'd3; b0 = 64'd5;
        req1 = 1'b1; op1 = 1'b0; a1 = 32'd6; b1 = 64'h1_0000_0000;
        @(negedge clock);
        chk("tie_grant0", 64'(grant), 64'd0);
        chk("tie_opera1", 64'(u_opera1), 64'd3);
        serve(1'b0, 64'd15, 5, "tie0");
        req0 = 1'b0;
        @(negedge clock);
        chk("tie_drop0", 64'(done0), 64'd0);
        @(negedge clock);
        chk("tie_grant1", 64'(grant), 64'd1);
        chk("tie_start1", 64'(u_start), 64'd1);
        chk("tie_opera1b", 64'(u_opera1), 64'd6);
        serve(1'b1, 64'h6_0000_0000, 5, "tie1");
        req1 = 1'b0;
        @(negedge clock);
        chk("tie_drop1", 64'(done1), 64'd0);

        // second simultaneous pair: last served was port 1, so port 0 wins
        req0 = 1'b1; a0 = 32'd9; b0 = 64'd9;
        req1 = 1'b1; a1 = 32'd1; b1 = 64'd77;
        @(negedge clock);
        chk("pair2_grant0", 64'(grant), 64'd0);
        serve(1'b0, 64'd81, 5, "pair2_0");
        req0 = 1'b0;
        repeat (2) @(negedge clock);
        chk("pair2_grant1", 64'(grant), 64'd1);
        serve(1'b1, 64'd77, 5, "pair2_1");
        req1 = 1'b0;
        @(negedge clock);
        chk("bad_done1", 64'(bad1), 64'd0);
        chk("bad_done0", 64'(bad0), 64'd0);
        chk("nstart5", 64'(nstart), 64'd5);

        // stale valid from the previous op must be ignored: 1000 / 10 = 100
        lat = 12;
        req0 = 1'b1; op0 = 1'b1; a0 = 32'd10; b0 = 64'd1000;
        @(negedge clock);
        chk("stale_start", 64'(u_start), 64'd1);
        serve(1'b0, 64'h0000_0000_0000_0064, 13, "stale");
        req0 = 1'b0;
        @(negedge clock);

        // watchdog on port 1 (TIMEOUT = 16)
        never = 1'b1;
        req1 = 1'b1; op1 = 1'b0; a1 = 32'd5; b1 = 64'd5;
        @(negedge clock);
        chk("to_grant", 64'(grant), 64'd1);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!done1 && cyc < 100);
        chk("to_lat", 64'(cyc), 64'd18);
        chk("to_err1", 64'(err1), 64'd1);
        chk("to_res1", res1, 64'd0);
        chk("to_ureset1", 64'(u_reset), 64'd1);
        @(negedge clock);
        chk("to_ureset2", 64'(u_reset), 64'd1);
        @(negedge clock);
        chk("to_ureset3", 64'(u_reset), 64'd0);
        chk("to_hold", 64'(done1), 64'd1);
        chk("to_err0", 64'(err0), 64'd0);
        req1 = 1'b0;
        @(negedge clock);
        chk("to_drop", 64'(done1), 64'd0);
        chk("to_errclr", 64'(err1), 64'd0);
        chk("to_idle", 64'(busy), 64'd0);

        // port 1 recovers after the flush: 21 * 2 = 42
        never = 1'b0; lat = 6;
        req1 = 1'b1; a1 = 32'd2; b1 = 64'd21;
        @(negedge clock);
        chk("rec_grant", 64'(grant), 64'd1);
        serve(1'b1, 64'd42, 7, "rec");
        req1 = 1'b0;
        @(negedge clock);

        // reset in the middle of WAIT
        lat = 20;
        req0 = 1'b1; op0 = 1'b0; a0 = 32'd1; b0 = 64'd1;
        @(negedge clock);
        repeat (5) @(negedge clock);
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0; req0 = 1'b0;
        @(negedge clock);
        chk("mid_done0", 64'(done0), 64'd0);
        chk("mid_busy0", 64'(busy), 64'd0);
        chk("mid_ureset", 64'(u_reset), 64'd1);
        chk("mid_opera1", 64'(u_opera1), 64'd0);
        chk("mid_opera2", u_opera2, 64'd0);
        chk("mid_start", 64'(u_start), 64'd0);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        chk("mid_quiet", 64'(done0), 64'd0);
        lat = 4;
        req0 = 1'b1; a0 = 32'd11; b0 = 64'd3;
        @(negedge clock);
        chk("post_busy", 64'(busy), 64'd1);
        serve(1'b0, 64'd33, 5, "post");
        req0 = 1'b0;
        @(negedge clock);
        chk("post_drop", 64'(done0), 64'd0);
        chk("nstart10", 64'(nstart), 64'd10);
        chk("no_double_start", 64'(dbl), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
